// File: rtl/regscan_pkg.sv
// Shared types and default sizing for the register-file scan reader.
package regscan_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CAPT,
        PRESENT
    } scan_state_t;

endpackage

// File: rtl/scan_index_counter.sv
// Window index tracker for the scan reader: holds the current, first and last
// index of the latched window and flags when the current index is the last one.
module scan_index_counter #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic          restart,
    input  logic [AW-1:0] load_first,
    input  logic [AW-1:0] load_last,
    output logic [AW-1:0] cur,
    output logic          at_last
);

    logic [AW-1:0] cur_q;
    logic [AW-1:0] first_q;
    logic [AW-1:0] last_q;

    // The first index is kept so a repeating scan can rewind to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else if (load) begin
            cur_q   <= load_first;
            first_q <= load_first;
            last_q  <= load_last;
        end else if (restart) begin
            cur_q <= first_q;
        end else if (inc) begin
            cur_q <= (cur_q == AW'(NREG - 1)) ? '0 : cur_q + AW'(1);
        end
    end

    assign cur     = cur_q;
    assign at_last = (cur_q == last_q);

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks a window of register-file indices over the debug read port and streams
// index/value pairs out. Define REGSCAN_AUTO_EN to rescan the window continuously.
module regfile_scan_reader
    import regscan_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] start_idx,
    input  logic [AW-1:0] end_idx,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_index,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    scan_state_t   state_q, state_d;
    logic          load, inc, restart, capture, clear_valid, done_d;
    logic [AW-1:0] cur;
    logic          at_last;
    logic          xfer;

    scan_index_counter #(
        .NREG (NREG),
        .AW   (AW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .inc        (inc),
        .restart    (restart),
        .load_first (start_idx),
        .load_last  (end_idx),
        .cur        (cur),
        .at_last    (at_last)
    );

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort overrides whatever the state would otherwise do, except in IDLE.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        inc         = 1'b0;
        restart     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = CAPT;
            CAPT: begin
                capture = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (xfer) begin
                    clear_valid = 1'b1;
                    if (at_last) begin
                        done_d = 1'b1;
`ifdef REGSCAN_AUTO_EN
                        restart = 1'b1;
                        state_d = ADDR;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        inc     = 1'b1;
                        state_d = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            inc         = 1'b0;
            restart     = 1'b0;
            capture     = 1'b0;
            clear_valid = 1'b1;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_d;
            if (capture) begin
                out_valid <= 1'b1;
                out_index <= cur;
                out_data  <= rd_data;
            end else if (clear_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The current index register doubles as the registered read address.
    assign rd_addr = cur;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench for regfile_scan_reader: stimulus queues expected index/data
// pairs from a window model; a negedge monitor pops and compares on each transfer.
module tb_regfile_scan_reader;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, out_ready;
    logic [AW-1:0] start_idx, end_idx, rd_addr, out_index;
    logic [DW-1:0] rd_data, out_data;
    logic          out_valid, busy, done;

    logic [DW-1:0] regs [NREG];
    entry_t        expQ[$];

    int nTests     = 0;
    int nFail      = 0;
    int doneCount  = 0;
    int doneCycle  = -1;
    int cycle      = 0;
    int readyMode  = 0;
    int stallLeft  = 0;

    logic          pv = 1'b0, pr = 1'b0, pa = 1'b0;
    logic [AW-1:0] pi = '0;
    logic [DW-1:0] pd = '0;

    regfile_scan_reader #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .start_idx (start_idx),
        .end_idx   (end_idx),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Register-file debug port model: synchronous read.
    always @(posedge clk) rd_data <= regs[rd_addr];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        nTests++;
        nFail++;
        $display("[TB] FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: stability while stalled, transfer scoreboard, done counting.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr && !pa) begin
                    checkOutput("hold_valid", 64'(out_valid), 64'd1);
                    checkOutput("hold_index", 64'(out_index), 64'(pi));
                    checkOutput("hold_data", 64'(out_data), 64'(pd));
                end
                if (done) begin
                    doneCount++;
                    doneCycle = cycle;
                end
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("[TB] FAIL unexpected_xfer: got index %0d data %0h expected none", out_index, out_data);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("xfer_index", 64'(out_index), 64'(e.idx));
                        checkOutput("xfer_data", 64'(out_data), 64'(e.data));
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pa = abort;
                pi = out_index;
                pd = out_data;
            end
        end
    end

    // Consumer ready pattern, selected per test.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && out_index == AW'(4) && stallLeft > 0) begin
                        out_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = !(out_valid && out_index == AW'(3));
            endcase
        end
    end

    function automatic int windowLen(input int s, input int e);
        return ((e - s + NREG) % NREG) + 1;
    endfunction

    task automatic pushWindow(input int s, input int e, input int reps);
        int n;
        int idx;
        n = windowLen(s, e);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < n; k++) begin
                idx = (s + k) % NREG;
                expQ.push_back('{idx: AW'(idx), data: regs[idx]});
            end
        end
    endtask

    task automatic pulseStart(input int s, input int e, output int c0);
        @(posedge clk);
        #1;
        start_idx = AW'(s);
        end_idx   = AW'(e);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0    = cycle;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic applyStimulus(input int s, input int e, input bit latency, input bit midStart);
        int  c0;
        int  d0;
        bit  seen;
        pushWindow(s, e, 1);
        d0 = doneCount;
        pulseStart(s, e, c0);
        if (midStart) begin
            @(posedge clk);
            #1;
            start_idx = AW'((s + 11) % NREG);
            end_idx   = AW'((e + 5) % NREG);
            start     = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (doneCount != d0) seen = 1'b1;
        end
        if (!seen) begin
            failNow("done_wait");
        end else begin
            checkOutput("done_high", 64'(done), 64'd1);
            checkOutput("busy_low_with_done", 64'(busy), 64'd0);
            checkOutput("done_count", 64'(doneCount - d0), 64'd1);
            if (latency)
                checkOutput("done_latency", 64'(doneCycle - c0), 64'(3 * windowLen(s, e)));
            checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        end
        expQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_out_index"}, 64'(out_index), 64'd0);
        checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int c0;
        int d0;
        bit seen;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        start_idx = '0;
        end_idx   = '0;
        for (int i = 0; i < NREG; i++) regs[i] = DW'(32'h100 + i);
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

`ifdef REGSCAN_AUTO_EN
        readyMode = 0;
        pushWindow(2, 3, 3);
        d0 = doneCount;
        pulseStart(2, 3, c0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            #1;
            checkOutput("auto_busy", 64'(busy), 64'd1);
            if (doneCount - d0 >= 3) seen = 1'b1;
        end
        if (!seen) failNow("auto_done_wait");
        checkOutput("auto_queue_empty", 64'(expQ.size()), 64'd0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("auto_abort_busy", 64'(busy), 64'd0);
        checkOutput("auto_abort_valid", 64'(out_valid), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("auto_done_total", 64'(doneCount - d0), 64'd3);
        expQ.delete();
`else
        readyMode = 0;
        applyStimulus(0, 31, 1'b1, 1'b0);

        readyMode = 2;
        stallLeft = 5;
        applyStimulus(0, 7, 1'b0, 1'b0);
        checkOutput("stall_used", 64'(stallLeft), 64'd0);

        readyMode = 0;
        applyStimulus(30, 1, 1'b1, 1'b0);
        applyStimulus(7, 7, 1'b1, 1'b1);

        // Abort while index 3 is held in PRESENT.
        readyMode = 3;
        pushWindow(0, 9, 1);
        d0 = doneCount;
        pulseStart(0, 9, c0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_index == AW'(3)) seen = 1'b1;
        end
        if (!seen) failNow("abort_wait_idx3");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_left", 64'(expQ.size()), 64'd7);
        expQ.delete();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(doneCount - d0), 64'd0);

        // Asynchronous reset in the middle of a scan.
        readyMode = 0;
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        pushWindow(5, 20, 1);
        pulseStart(5, 20, c0);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        readyMode = 1;
        for (int t = 0; t < 6; t++) begin
            int s;
            int e;
            for (int i = 0; i < NREG; i++) regs[i] = $urandom;
            s = int'($urandom_range(0, NREG - 1));
            e = int'($urandom_range(0, NREG - 1));
            applyStimulus(s, e, 1'b0, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_scan_reader.md
# regfile_scan_reader

Read-side sequencer for the CPU's 32×32 register file, used to dump register contents to the FPGA debug/display path. On `start` it walks a window of register indices, issues synchronous reads on the register file's debug read port, and presents each value with its index over a valid/ready stream. It sits between the register file's debug read port and the display/UART formatter.

## Interface
- `NREG`, 32, number of registers scanned; power of two.
- `AW`, 5, index width; log2(`NREG`).
- `DW`, 32, data width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin scan; sampled only in IDLE.
- `abort` in 1: terminate scan; effective in any non-IDLE state.
- `start_idx` in AW: first index, latched on start acceptance.
- `end_idx` in AW: last index, inclusive, latched on start acceptance.
- `rd_addr` out AW: register-file debug read address; registered output.
- `rd_data` in DW: register-file debug read data, valid one edge after `rd_addr` changes.
- `out_valid` out 1: `out_index`/`out_data` valid.
- `out_ready` in 1: consumer accepts when high together with `out_valid`.
- `out_index` out AW: index of the presented value.
- `out_data` out DW: presented register value.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last entry of a window is accepted.

## Operation
- States: IDLE, ADDR, CAPT, PRESENT.
- IDLE: `busy`=0. With `start`=1 at an edge: latch `cur`=`start_idx` and `last`=`end_idx`, set `rd_addr`=`start_idx`, go to ADDR.
- ADDR: wait one edge for the register-file read, then go to CAPT.
- CAPT: at the edge, load `out_data`=`rd_data` and `out_index`=`cur`, set `out_valid`=1, go to PRESENT.
- PRESENT: hold `out_valid`, `out_data` and `out_index` stable until `out_valid`&`out_ready` at an edge. On that transfer, clear `out_valid` and then:
  - if `cur`==`last`: pulse `done` and go to IDLE;
  - otherwise: `cur`=(`cur`+1) mod `NREG`, `rd_addr`=new `cur`, go to ADDR.
- Wrap-around: if `end_idx` < `start_idx`, the scan runs through `NREG`-1, wraps to 0, and continues to `end_idx`. If `start_idx`==`end_idx`, exactly one entry is presented. A full sweep uses `start_idx`=0, `end_idx`=`NREG`-1.
- `start` while `busy`: ignored. The latched window does not change.
- `abort`=1 at any edge outside IDLE:
  - next state is IDLE;
  - `out_valid` cleared;
  - no `done` pulse;
  - a transfer in the same cycle is still counted as accepted by the consumer.
- `abort` and `start` in the same cycle in IDLE: `start` wins, because `abort` has no effect in IDLE.
- Reset (any time, including mid-scan): state IDLE; `rd_addr`=0, `out_valid`=0, `out_index`=0, `out_data`=0, `busy`=0, `done`=0; internal `cur`/`last`=0.

## Timing
- Start sampled at edge E0. `rd_addr` is valid after E0, `rd_data` after E1, and `out_valid` rises after E2.
- Per-entry cost: 3 cycles with `out_ready` held high. This gives 3·N cycles from start acceptance to the final transfer for N entries.
- `done` is high for the single cycle following the last transfer edge.
- `busy` rises after E0 and falls in the same cycle that `done` is high.
- `out_valid` never deasserts without a transfer except on `abort` or `rst`.

## Configuration
- `REGSCAN_AUTO_EN` defined: after the last transfer, pulse `done` as usual. Then, instead of going to IDLE, restart at the latched `start_idx` (`rd_addr`=`start_idx`, go to ADDR). Scanning continues until `abort` or `rst`, and `busy` stays 1 throughout.
- `REGSCAN_AUTO_EN` undefined: the scan stops in IDLE after one window, as described in Operation.

## Structure
- Shared package `regscan_pkg`: state enum {IDLE, ADDR, CAPT, PRESENT}, default `NREG`/`AW`/`DW` constants.
- One sub-module, `scan_index_counter`. It holds `cur`/`last`, supports load, increment mod `NREG`, and the `at_last` compare.
- The top level holds the FSM and output registers.

## Test plan
- Full sweep, `start_idx`=0, `end_idx`=31, `out_ready`=1, register file preloaded with value 0x100+i at index i → 32 transfers with index i / data 0x100+i, 3 cycles apart; `done` 96 cycles after start acceptance.
- Backpressure: `out_ready` low for 5 cycles during index 4 → `out_valid`, index 4 and data held stable for 5 cycles; then transfer; sequence continues to 5.
- Wrap: `start_idx`=30, `end_idx`=1 → indices 30, 31, 0, 1 in order, then `done`.
- Single entry, `start_idx`=`end_idx`=7 → one transfer of index 7, `done`; `start` pulsed mid-scan is ignored.
- Abort in PRESENT at index 3 → `out_valid`=0 and IDLE next cycle, no `done`; `rst` mid-scan → all outputs 0 immediately.
- With `REGSCAN_AUTO_EN`, window 2..3 → indices 2, 3, then `done` pulse, then 2, 3 repeat with `busy`=1 until `abort`.
